// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one 8N1 serial transmitter among NUM_REQ byte-stream requesters.
// Optional build macro UART_ARB_ID_HDR_EN prefixes each message with header {4'hA, grant_id}.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_data_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    input  logic                 tx_done,
    output logic [IDX_W-1:0]     grant_id,
    output logic                 busy
);

`ifdef UART_ARB_ID_HDR_EN
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2,
        HDR_ISSUE = 3'd3,
        HDR_WAIT  = 3'd4
    } state_t;
    logic [7:0]       payload_r;
`else
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_DONE = 3'd2
    } state_t;
`endif

    state_t           state_r;
    state_t           state_s;
    logic [IDX_W-1:0] rr_ptr_r;
    logic             lock_r;
    logic [IDX_W-1:0] grant_id_r;
    logic             last_q_r;
    logic [7:0]       tx_data_r;
    logic             tx_data_valid_r;

    logic [IDX_W-1:0] sel_s;
    logic             found_s;
    logic             accept_s;
    logic [7:0]       data_sel_s;
    logic             last_sel_s;
    logic             done_msg_s;
    logic [IDX_W-1:0] rr_next_s;

    // Requester selection: locked owner, else first valid at or after the rr pointer
    always_comb begin
        int idx;
        idx     = 0;
        sel_s   = grant_id_r;
        found_s = 1'b0;
        if (lock_r) begin
            sel_s   = grant_id_r;
            found_s = req_valid[grant_id_r];
        end else begin
            // Descending scan so the smallest rotated offset is the last to win
            for (int k = NUM_REQ - 1; k >= 0; k--) begin
                idx = int'(rr_ptr_r) + k;
                idx = (idx >= NUM_REQ) ? (idx - NUM_REQ) : idx;
                sel_s   = req_valid[idx] ? IDX_W'(idx) : sel_s;
                found_s = req_valid[idx] ? 1'b1 : found_s;
            end
        end
    end

    assign accept_s   = (state_r == IDLE) && !tx_busy && found_s;
    assign data_sel_s = req_data[{sel_s, 3'b000} +: 8];
    assign last_sel_s = req_last[sel_s];
    assign done_msg_s = (state_r == WAIT_DONE) && tx_done;
    assign rr_next_s  = (grant_id_r == IDX_W'(NUM_REQ - 1)) ? {IDX_W{1'b0}}
                                                           : (grant_id_r + IDX_W'(1));

    // One-hot ready toward the selected requester
    always_comb begin
        req_ready = {NUM_REQ{1'b0}};
        if (accept_s) begin
            req_ready[sel_s] = 1'b1;
        end else begin
            req_ready = {NUM_REQ{1'b0}};
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
`ifdef UART_ARB_ID_HDR_EN
                    state_s = lock_r ? ISSUE : HDR_ISSUE;
`else
                    state_s = ISSUE;
`endif
                end else begin
                    state_s = IDLE;
                end
            end
            ISSUE:     state_s = WAIT_DONE;
            WAIT_DONE: state_s = tx_done ? IDLE : WAIT_DONE;
`ifdef UART_ARB_ID_HDR_EN
            HDR_ISSUE: state_s = HDR_WAIT;
            HDR_WAIT:  state_s = tx_done ? ISSUE : HDR_WAIT;
`endif
            default:   state_s = IDLE;
        endcase
    end

    // Transmit pulse registered so it is high exactly in the issue states
`ifdef UART_ARB_ID_HDR_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_data_valid_r <= 1'b0;
        end else begin
            tx_data_valid_r <= (state_s == ISSUE) || (state_s == HDR_ISSUE);
        end
    end
`else
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_data_valid_r <= 1'b0;
        end else begin
            tx_data_valid_r <= (state_s == ISSUE);
        end
    end
`endif

    // Captured byte, owner and end-of-message flag at acceptance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tx_data_r  <= 8'h00;
            grant_id_r <= {IDX_W{1'b0}};
            last_q_r   <= 1'b0;
`ifdef UART_ARB_ID_HDR_EN
            payload_r  <= 8'h00;
`endif
        end else if (accept_s) begin
            grant_id_r <= sel_s;
            last_q_r   <= last_sel_s;
`ifdef UART_ARB_ID_HDR_EN
            payload_r  <= data_sel_s;
            tx_data_r  <= lock_r ? data_sel_s : {4'hA, 4'(sel_s)};
        end else if ((state_r == HDR_WAIT) && tx_done) begin
            tx_data_r  <= payload_r;
`else
            tx_data_r  <= data_sel_s;
`endif
        end
    end

    // Message lock and round-robin pointer advance on the payload done
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            lock_r   <= 1'b0;
            rr_ptr_r <= {IDX_W{1'b0}};
        end else if (done_msg_s) begin
            lock_r   <= !last_q_r;
            rr_ptr_r <= last_q_r ? rr_next_s : rr_ptr_r;
        end
    end

    assign tx_data_valid = tx_data_valid_r;
    assign tx_data       = tx_data_r;
    assign grant_id      = grant_id_r;
    assign busy          = (state_r != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: requester queues, transmitter model, byte scoreboard.
module tb_uart_tx_arbiter;
    localparam int NUM_REQ  = 4;
    localparam int IDX_W    = 2;
    localparam int DONE_DLY = 10;

    logic                 clock;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 tx_data_valid;
    logic [7:0]           tx_data;
    logic                 tx_busy;
    logic                 tx_done;
    logic [IDX_W-1:0]     grant_id;
    logic                 busy;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data_valid(tx_data_valid), .tx_data(tx_data),
        .tx_busy(tx_busy), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy)
    );

    typedef struct {
        logic [7:0]       data;
        logic [IDX_W-1:0] id;
    } exp_t;

    typedef struct {
        logic [NUM_REQ-1:0] mask;
        int                 n;
        logic [15:0]        order;
        logic [IDX_W-1:0]   last_grant;
    } vec_t;

    exp_t       sbq[$];
    logic [8:0] rq[NUM_REQ][$];
    int         rdy_cnt[NUM_REQ];
    logic [NUM_REQ-1:0] acc_pend;
    int  total = 0;
    int  bad   = 0;
    int  pulse_cnt = 0;
    int  done_cnt  = 0;
    bit  spur_req  = 1'b0;

`ifdef UART_ARB_ID_HDR_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < NUM_REQ; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_exp(input int id, input logic [7:0] data, input bit first);
        if (HDR != 0 && first) sbq.push_back('{8'hA0 | 8'(id), IDX_W'(id)});
        sbq.push_back('{data, IDX_W'(id)});
    endtask

    task automatic clear_counts();
        for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clock); #2;
            if (sbq.size() == 0 && !busy && !tx_busy && rq_empty()) begin
                ok = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 32'(ok), 32'd1);
    endtask

    // Transmitter model: done pulse DONE_DLY clocks after each start pulse
    initial begin
        int cnt;
        exp_t e;
        cnt = 0; tx_busy = 1'b0; tx_done = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                tx_busy = 1'b0; tx_done = 1'b0; cnt = 0;
            end else if (tx_done) begin
                tx_done = 1'b0; tx_busy = 1'b0;
            end else if (tx_busy) begin
                if (tx_data_valid) begin
                    total++; bad++;
                    $display("FAIL valid_while_busy: actual=1 required=0");
                end
                if (cnt <= 1) begin tx_done = 1'b1; done_cnt++; end
                else cnt--;
            end else if (spur_req) begin
                tx_done = 1'b1; spur_req = 1'b0;
            end else if (tx_data_valid) begin
                tx_busy = 1'b1; cnt = DONE_DLY; pulse_cnt++;
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL tx_unexpected: actual=%0h required=none", tx_data);
                end else begin
                    e = sbq.pop_front();
                    check("tx_data", 32'(tx_data), 32'(e.data));
                    check("tx_grant", 32'(grant_id), 32'(e.id));
                end
            end
        end
    end

    // Requester driver: holds each queued byte until it sees it accepted
    initial begin
        req_valid = '0; req_data = '0; req_last = '0; acc_pend = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                for (int i = 0; i < NUM_REQ; i++) rq[i].delete();
                acc_pend = '0; req_valid = '0;
            end else begin
                for (int i = 0; i < NUM_REQ; i++)
                    if (acc_pend[i] && rq[i].size() > 0) void'(rq[i].pop_front());
                for (int i = 0; i < NUM_REQ; i++) begin
                    if (rq[i].size() > 0) begin
                        req_valid[i]        = 1'b1;
                        req_data[8*i +: 8]  = rq[i][0][7:0];
                        req_last[i]         = rq[i][0][8];
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
                #1;
                acc_pend = req_ready;
                for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rdy_cnt[i]++;
            end
        end
    end

    task automatic do_reset();
        @(negedge clock); #2;
        reset = 1'b0;
        @(negedge clock); @(negedge clock); #2;
        check("rst_tx_valid", 32'(tx_data_valid), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant_id), 32'd0);
        reset = 1'b1;
    endtask

    initial begin
        vec_t vecs[5];
        int   base_p, base_d, id;
        bit   ok;
        vecs[0] = '{4'b1101, 3, 16'h0230, 2'd3};
        vecs[1] = '{4'b0110, 2, 16'h1200, 2'd2};
        vecs[2] = '{4'b1001, 2, 16'h3000, 2'd0};
        vecs[3] = '{4'b1111, 4, 16'h1230, 2'd0};
        vecs[4] = '{4'b0001, 1, 16'h0000, 2'd0};
        reset = 1'b0;
        clear_counts();
        do_reset();

        // Single one-byte message from requester 1
        clear_counts();
        base_p = pulse_cnt; base_d = done_cnt;
        push_exp(1, 8'h5A, 1'b1);
        rq[1].push_back({1'b1, 8'h5A});
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clock); #2;
            if (done_cnt == base_d + 1 + HDR) begin ok = 1'b1; break; end
        end
        check("t1_done_timeout", 32'(ok), 32'd1);
        check("t1_busy_at_done", 32'(busy), 32'd1);
        @(negedge clock); #2;
        check("t1_busy_after_done", 32'(busy), 32'd0);
        wait_idle("t1");
        check("t1_ready_pulses", 32'(rdy_cnt[1]), 32'd1);
        check("t1_tx_pulses", 32'(pulse_cnt - base_p), 32'(1 + HDR));
        check("t1_grant", 32'(grant_id), 32'd1);

        // Table: simultaneous one-byte messages, round-robin order carried across rows
        do_reset();
        for (int v = 0; v < 5; v++) begin
            clear_counts();
            for (int k = 0; k < vecs[v].n; k++) begin
                id = int'(vecs[v].order[15-4*k -: 4]);
                push_exp(id, 8'(16*(v+1) + id), 1'b1);
            end
            for (int i = 0; i < NUM_REQ; i++)
                if (vecs[v].mask[i]) rq[i].push_back({1'b1, 8'(16*(v+1) + i)});
            wait_idle($sformatf("vec%0d", v));
            check($sformatf("vec%0d_grant", v), 32'(grant_id), 32'(vecs[v].last_grant));
            check($sformatf("vec%0d_ready_sum", v),
                  32'(rdy_cnt[0] + rdy_cnt[1] + rdy_cnt[2] + rdy_cnt[3]), 32'(vecs[v].n));
        end

        // Locked 3-byte message from requester 1 while requester 0 waits
        clear_counts();
        push_exp(1, 8'h01, 1'b1); push_exp(1, 8'h02, 1'b0); push_exp(1, 8'h03, 1'b0);
        push_exp(0, 8'h40, 1'b1);
        rq[1].push_back({1'b0, 8'h01}); rq[1].push_back({1'b0, 8'h02});
        rq[1].push_back({1'b1, 8'h03});
        rq[0].push_back({1'b1, 8'h40});
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock); #2;
            if (rq[1].size() == 0) begin ok = 1'b1; break; end
        end
        check("t3_drain_timeout", 32'(ok), 32'd1);
        check("t3_ready0_locked_out", 32'(rdy_cnt[0]), 32'd0);
        wait_idle("t3");
        check("t3_ready0", 32'(rdy_cnt[0]), 32'd1);
        check("t3_ready1", 32'(rdy_cnt[1]), 32'd3);
        check("t3_grant", 32'(grant_id), 32'd0);

        // Spurious done in IDLE is ignored
        base_p = pulse_cnt;
        spur_req = 1'b1;
        repeat (4) @(negedge clock);
        #2;
        check("spur_fired", 32'(spur_req), 32'd0);
        check("spur_tx_pulses", 32'(pulse_cnt - base_p), 32'd0);
        check("spur_busy", 32'(busy), 32'd0);
        check("spur_grant", 32'(grant_id), 32'd0);

        // Reset during WAIT_DONE of a locked message
        clear_counts();
        push_exp(2, 8'h21, 1'b1); push_exp(2, 8'h22, 1'b0);
        rq[2].push_back({1'b0, 8'h21}); rq[2].push_back({1'b1, 8'h22});
        rq[0].push_back({1'b1, 8'h30});
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock); #2;
            if (rdy_cnt[2] == 2) begin ok = 1'b1; break; end
        end
        check("t5_second_accept_timeout", 32'(ok), 32'd1);
        repeat (3) @(negedge clock);
        #2;
        check("t5_busy_before_reset", 32'(busy), 32'd1);
        check("t5_ready0_locked_out", 32'(rdy_cnt[0]), 32'd0);
        check("t5_sb_drained", 32'(sbq.size()), 32'd0);
        do_reset();
        clear_counts();
        push_exp(0, 8'h30, 1'b1); push_exp(3, 8'h33, 1'b1);
        rq[3].push_back({1'b1, 8'h33});
        rq[0].push_back({1'b1, 8'h30});
        wait_idle("t5_after");
        check("t5_grant", 32'(grant_id), 32'd3);

        // Two-byte message from requester 2 (header prefixed when enabled)
        base_p = pulse_cnt;
        push_exp(2, 8'hC1, 1'b1); push_exp(2, 8'hC2, 1'b0);
        rq[2].push_back({1'b0, 8'hC1}); rq[2].push_back({1'b1, 8'hC2});
        wait_idle("t6");
        check("t6_tx_pulses", 32'(pulse_cnt - base_p), 32'(2 + HDR));
        check("t6_grant", 32'(grant_id), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one 8N1 serial transmitter between NUM_REQ byte-stream requesters using round-robin arbitration.
- Accepts one byte at a time from the granted requester and issues it to the transmitter as a one-cycle data-valid pulse.
- Waits for the transmitter's done pulse before issuing the next byte.
- Supports multi-byte messages: a requester keeps the grant until it transfers a byte flagged last, so messages never interleave on the serial line.

Parameters:
NUM_REQ, 4, number of requesters; legal range 2..16.
IDX_W, 2, width of grant index; must equal ceil(log2(NUM_REQ)).

Ports:
reset  input  1  asynchronous, active-low reset
clock  input  1  system clock
req_valid  input  NUM_REQ  per-requester byte available
req_data  input  8*NUM_REQ  per-requester byte; requester i occupies bits [8i+7:8i]
req_last  input  NUM_REQ  byte is the final byte of its message
req_ready  output  NUM_REQ  byte accepted this cycle (combinational)
tx_data_valid  output  1  one-cycle start pulse to the transmitter (registered)
tx_data  output  8  byte to transmit (registered)
tx_busy  input  1  transmitter is mid-frame
tx_done  input  1  one-cycle pulse when the stop bit completes
grant_id  output  IDX_W  index of the current or last granted requester
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, reset low) values:
  - state IDLE, rr pointer 0, lock 0, grant_id 0
  - tx_data_valid 0, tx_data 8'h00, req_ready all 0, busy 0
  - Reset mid-frame abandons the byte; no req_ready is re-issued for it. The transmitter shares the same reset.
- Selection (IDLE, lock=0): search req_valid starting at the rr pointer, ascending, wrapping at NUM_REQ-1 to 0. The first set bit is sel.
- Selection (IDLE, lock=1): sel = grant_id. Other requesters are ignored even if valid.
- req_ready[i] = (state==IDLE) & ~tx_busy & req_valid[i] & (i==sel). At most one bit is ever high.
- Transfer happens on the edge where req_valid&req_ready is high. On that edge:
  - tx_data <= req_data[sel]
  - grant_id <= sel
  - last_q <= req_last[sel]
  - state -> ISSUE
- ISSUE: tx_data_valid=1 for exactly this one cycle; next state WAIT_DONE.
- WAIT_DONE: hold until tx_done=1. Then:
  - if last_q=0: lock <= 1 and state -> IDLE, with the grant held on the same requester.
  - if last_q=1: lock <= 0, rr pointer <= (grant_id+1) mod NUM_REQ, state -> IDLE.
- Throughput: from the done cycle, the next byte can be accepted the following cycle, giving 2 clocks of overhead per byte (IDLE accept + ISSUE).
- tx_done in any state other than WAIT_DONE is ignored.
- Simultaneous valid on several requesters: only the round-robin winner is served. Requesters must hold req_valid, req_data and req_last stable until accepted.
- A locked requester dropping req_valid stalls the arbiter in IDLE with busy=0 and the lock retained; no timeout.
- A single byte with req_last=1 is a one-byte message.

Optional Feature:
Macro UART_ARB_ID_HDR_EN.
- Defined: the first byte of each message (accepted while lock=0) is preceded by a header byte {4'hA, grant_id zero-extended to 4 bits}.
  - Path: accept -> HDR_ISSUE (tx_data_valid pulse, tx_data = header) -> HDR_WAIT (wait for tx_done) -> ISSUE (payload byte, already latched) -> WAIT_DONE.
  - Bytes accepted while lock=1 get no header.
- Undefined: the HDR states and header logic are absent; the byte stream is exactly the payload.

Test Plan:
- Single requester 1, byte 8'h5A with last=1, transmitter model done 10 clocks after its pulse:
  - req_ready[1] pulses once and tx_data_valid pulses once with tx_data=8'h5A.
  - grant_id=1; busy falls the cycle after tx_done.
- Requesters 0, 2 and 3 all valid with one-byte messages (8'h10, 8'h12, 8'h13) from reset: transmit order is 0, 2, 3; the rr pointer ends at 0.
- Requester 1 sends 3-byte message 8'h01, 8'h02, 8'h03 (last on the third) while requester 0 holds a byte valid:
  - all three bytes of requester 1 go out before requester 0's byte.
  - req_ready[0] stays 0 throughout.
- Reset asserted during WAIT_DONE of a locked message: all outputs return to reset values; after release, requester 0 is granted first.
- Spurious tx_done pulse in IDLE with no requests: no state change and no tx_data_valid.
- With UART_ARB_ID_HDR_EN defined, requester 2 sends 2-byte message 8'hC1, 8'hC2: the transmitted sequence is 8'hA2, 8'hC1, 8'hC2.
